instr_fetch_issue: RTL and testbench

- Front end of the NN processor pipeline: fetches 16-bit instruction words from instruction memory and issues them to the decode/control stage.
- Maintains the PC and a 2-entry in-order prefetch buffer.
- Splits each word into opcode/register fields for the decoder.
- Detects HALT (4'hB) and illegal opcodes, stops fetching after HALT, and reports halted status.

---
 rtl/instr_fetch_issue_if.sv | 36 +++
 rtl/instr_fetch_issue.sv | 139 +++++++++++++
 tb/tb_instr_fetch_issue.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_issue_if.sv
// Bundle of start, instruction-memory and decode-issue signals for the fetch front end.
// master: the fetch/issue unit; slave: the surrounding pipeline and memory.
interface instr_fetch_issue_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               start;
  logic [ADDR_W-1:0]  start_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               dec_valid;
  logic               dec_ready;
  logic [3:0]         dec_opcode;
  logic [3:0]         dec_rd;
  logic [3:0]         dec_rs;
  logic [3:0]         dec_rt;
  logic [ADDR_W-1:0]  dec_pc;
  logic               illegal;
  logic               halted;
  logic               busy;

  modport master (
    input  start, start_pc, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_opcode, dec_rd, dec_rs, dec_rt,
           dec_pc, illegal, halted, busy
  );

  modport slave (
    output start, start_pc, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_opcode, dec_rd, dec_rs, dec_rt,
           dec_pc, illegal, halted, busy
  );
endinterface

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: PC, credit-limited fetch, in-order prefetch buffer,
// field split for decode, illegal-opcode squash and HALT drain.
module instr_fetch_issue #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  instr_fetch_issue_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [3:0]  OpHalt = 4'hB;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalted} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [CntW-1:0]    count_q;
  logic [CntW-1:0]    outst_q;
  logic [CntW-1:0]    outst_d;
  logic [PtrW-1:0]    head_q;
  logic [PtrW-1:0]    tail_q;
  logic [INSTR_W-1:0] word_q [DEPTH];
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic               halt_seen_q;
  logic               halted_q;
  logic               busy_q;

  logic [INSTR_W-1:0] head_word;
  logic [3:0]         head_op;
  logic               op_legal;
  logic               resp_fire;
  logic               resp_halt;
  logic               credit;
  logic               req_valid;
  logic               req_fire;
  logic               push;
  logic               dec_valid;
  logic               pop;
  logic               head_halt;
  logic [ADDR_W-1:0]  resp_addr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_word = word_q[head_q];
    head_op   = head_word[15:12];
    op_legal  = 1'b0;
    case (head_op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hB, 4'hE, 4'hF: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase

    // Responses with nothing outstanding are strays (e.g. from before a reset).
    resp_fire = bus.imem_resp_valid && (outst_q != '0);
    resp_halt = resp_fire && (state_q == StRun) && (bus.imem_resp_data[15:12] == OpHalt);
    credit    = ({1'b0, count_q} + {1'b0, outst_q}) < SumW'(DEPTH);
    req_valid = (state_q == StRun) && credit && !resp_halt;
    req_fire  = req_valid && bus.imem_req_ready;
    push      = resp_fire && (state_q == StRun);
    dec_valid = (count_q != '0);
    pop       = dec_valid && bus.dec_ready;
    head_halt = (head_op == OpHalt);
    outst_d   = outst_q + CntW'(req_fire) - CntW'(resp_fire);
    // Requests are sequential and responses in order, so the oldest outstanding address
    // trails the PC by the outstanding count.
    resp_addr = pc_q - ADDR_W'(outst_q);
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_opcode     = (dec_valid && op_legal) ? head_op : 4'h0;
  assign bus.dec_rd         = dec_valid ? head_word[11:8] : 4'h0;
  assign bus.dec_rs         = dec_valid ? head_word[7:4] : 4'h0;
  assign bus.dec_rt         = dec_valid ? head_word[3:0] : 4'h0;
  assign bus.dec_pc         = dec_valid ? addr_q[head_q] : '0;
  assign bus.illegal        = pop && !op_legal;
  assign bus.halted         = halted_q;
  assign bus.busy           = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      outst_q <= outst_d;
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (req_fire) pc_q <= pc_q + 1'b1;
      if (push) begin
        word_q[tail_q] <= bus.imem_resp_data;
        addr_q[tail_q] <= resp_addr;
        tail_q         <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      if (pop && head_halt) halt_seen_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (bus.start) begin
            pc_q    <= bus.start_pc;
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (resp_halt) state_q <= StDrain;
        end
        StDrain: begin
          if ((halt_seen_q || (pop && head_halt)) && (outst_d == '0)) begin
            state_q  <= StHalted;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        StHalted: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: memory model with fixed latency, issue log and
// per-scenario tasks with hand-computed expectations.
module tb_instr_fetch_issue;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       ill;
    int         cyc;
  } iss_t;

  logic clk;
  logic reset_n;

  instr_fetch_issue_if bus ();

  instr_fetch_issue dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_bad;
  int         cyc;
  logic [15:0] mem [256];
  logic       pv [8];
  logic [7:0] pa [8];
  int         lat;
  logic       stray;
  logic [7:0] req_log [$];
  iss_t       iss_log [$];
  int         ill_cycles;
  int         halted_cyc;
  int         last_resp_cyc;

  task automatic clear_logs();
    req_log.delete();
    iss_log.delete();
    ill_cycles    = 0;
    halted_cyc    = -1;
    last_resp_cyc = -1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // One clock: sample handshakes away from the edge, advance, then drive memory responses.
  task automatic tick();
    logic       acc;
    logic [7:0] a;
    iss_t       e;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    a   = bus.imem_req_addr;
    if (acc) req_log.push_back(a);
    if (bus.dec_valid && bus.dec_ready) begin
      e.pc  = bus.dec_pc;
      e.op  = bus.dec_opcode;
      e.rd  = bus.dec_rd;
      e.rs  = bus.dec_rs;
      e.rt  = bus.dec_rt;
      e.ill = bus.illegal;
      e.cyc = cyc;
      iss_log.push_back(e);
    end
    if (bus.illegal) ill_cycles++;
    if (bus.imem_resp_valid) last_resp_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i + 1];
      pa[i] = pa[i + 1];
    end
    pv[7] = 1'b0;
    pa[7] = 8'h00;
    if (acc) begin
      pv[lat - 1] = 1'b1;
      pa[lat - 1] = a;
    end
    bus.imem_resp_valid = pv[0] || stray;
    bus.imem_resp_data  = pv[0] ? mem[pa[0]] : (stray ? 16'h1234 : 16'h0000);
    #1;
    if (bus.halted && halted_cyc < 0) halted_cyc = cyc;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    stray     = 1'b0;
    for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic do_start(input logic [7:0] pc);
    bus.start    = 1'b1;
    bus.start_pc = pc;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (bus.halted !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    n_cmp++;
    if (bus.halted !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_halt_timeout: halted=%b required 1", name, bus.halted);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.imem_req_valid, bus.imem_req_addr, bus.dec_valid, bus.dec_opcode, bus.dec_rd,
         bus.dec_rs, bus.dec_rt, bus.dec_pc, bus.illegal, bus.halted, bus.busy} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: req_v=%b addr=%h dec_v=%b op=%h pc=%h halted=%b busy=%b, req 0",
               bus.imem_req_valid, bus.imem_req_addr, bus.dec_valid, bus.dec_opcode,
               bus.dec_pc, bus.halted, bus.busy);
    end
    tick();
    reset_n = 1'b1;
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: req_v=%b busy=%b required 0/0", bus.imem_req_valid, bus.busy);
    end
    n_cmp++;
    if (iss_log.size() !== 0 || bus.dec_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_stray: issued=%0d dec_v=%b required 0/0",
               iss_log.size(), bus.dec_valid);
    end
  endtask

  task automatic test_straight();
    logic [7:0] exp_pc [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [3:0] exp_op [4] = '{4'h1, 4'h9, 4'h4, 4'hB};
    do_reset();
    clear_mem();
    mem[8'h10] = 16'h1123;
    mem[8'h11] = 16'h9456;
    mem[8'h12] = 16'h4789;
    mem[8'h13] = 16'hB000;
    mem[8'h14] = 16'h1FFF;
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    do_start(8'h10);
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'h10 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL straight_first_req: v=%b addr=%h busy=%b required 1/10/1",
               bus.imem_req_valid, bus.imem_req_addr, bus.busy);
    end
    run_to_halt("straight");
    n_cmp++;
    if (iss_log.size() !== 4) begin
      n_bad++;
      $display("FAIL straight_count: issued=%0d required 4", iss_log.size());
    end
    for (int i = 0; i < 4 && i < iss_log.size(); i++) begin
      n_cmp++;
      if (iss_log[i].pc !== exp_pc[i] || iss_log[i].op !== exp_op[i]) begin
        n_bad++;
        $display("FAIL straight_issue%0d: pc=%h op=%h required pc=%h op=%h", i,
                 iss_log[i].pc, iss_log[i].op, exp_pc[i], exp_op[i]);
      end
    end
    if (iss_log.size() > 0) begin
      n_cmp++;
      if ({iss_log[0].rd, iss_log[0].rs, iss_log[0].rt} !== 12'h123) begin
        n_bad++;
        $display("FAIL straight_fields: rd/rs/rt=%h/%h/%h required 1/2/3",
                 iss_log[0].rd, iss_log[0].rs, iss_log[0].rt);
      end
    end
    n_cmp++;
    if (req_log.size() !== 4 || (req_log.size() > 0 && req_log[$] !== 8'h13)) begin
      n_bad++;
      $display("FAIL straight_reqs: count=%0d required 4 ending at 13", req_log.size());
    end
    if (iss_log.size() == 4) begin
      n_cmp++;
      if (halted_cyc !== iss_log[3].cyc + 1) begin
        n_bad++;
        $display("FAIL straight_halt_timing: halted at %0d required %0d", halted_cyc,
                 iss_log[3].cyc + 1);
      end
    end
    repeat (3) tick();
    n_cmp++;
    if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL straight_halted_hold: halted=%b busy=%b req_v=%b required 1/0/0",
               bus.halted, bus.busy, bus.imem_req_valid);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_pc [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    logic [3:0] exp_op [5] = '{4'h2, 4'h3, 4'h0, 4'h1, 4'hB};
    int n = 0;
    do_reset();
    clear_mem();
    mem[8'h40] = 16'h2111;
    mem[8'h41] = 16'h3222;
    mem[8'h42] = 16'h0333;
    mem[8'h43] = 16'h1444;
    mem[8'h44] = 16'hB000;
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    do_start(8'h40);
    while (iss_log.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (iss_log.size() !== 1) begin
      n_bad++;
      $display("FAIL stall_first_issue: issued=%0d required 1", iss_log.size());
    end
    bus.dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 8'h41 || bus.dec_opcode !== 4'h3 ||
          bus.dec_rd !== 4'h2) begin
        n_bad++;
        $display("FAIL stall_hold%0d: v=%b pc=%h op=%h rd=%h required 1/41/3/2", k,
                 bus.dec_valid, bus.dec_pc, bus.dec_opcode, bus.dec_rd);
      end
      tick();
      n_cmp++;
      if (req_log.size() - iss_log.size() > 2) begin
        n_bad++;
        $display("FAIL stall_credit%0d: in flight=%0d required <=2", k,
                 req_log.size() - iss_log.size());
      end
    end
    bus.dec_ready = 1'b1;
    run_to_halt("stall");
    n_cmp++;
    if (iss_log.size() !== 5) begin
      n_bad++;
      $display("FAIL stall_count: issued=%0d required 5", iss_log.size());
    end
    for (int i = 0; i < 5 && i < iss_log.size(); i++) begin
      n_cmp++;
      if (iss_log[i].pc !== exp_pc[i] || iss_log[i].op !== exp_op[i]) begin
        n_bad++;
        $display("FAIL stall_issue%0d: pc=%h op=%h required pc=%h op=%h", i,
                 iss_log[i].pc, iss_log[i].op, exp_pc[i], exp_op[i]);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    clear_mem();
    mem[8'h60] = 16'h5ABC;
    mem[8'h61] = 16'h1DEF;
    mem[8'h62] = 16'hB000;
    mem[8'h63] = 16'h2000;
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    do_start(8'h60);
    run_to_halt("illegal");
    n_cmp++;
    if (iss_log.size() !== 3) begin
      n_bad++;
      $display("FAIL illegal_count: issued=%0d required 3", iss_log.size());
    end
    if (iss_log.size() >= 2) begin
      n_cmp++;
      if ({iss_log[0].pc, iss_log[0].op, iss_log[0].rd, iss_log[0].rs, iss_log[0].rt,
           iss_log[0].ill} !== {8'h60, 16'h0ABC, 1'b1}) begin
        n_bad++;
        $display("FAIL illegal_squash: pc=%h op=%h rd=%h rs=%h rt=%h ill=%b required 60/0/A/B/C/1",
                 iss_log[0].pc, iss_log[0].op, iss_log[0].rd, iss_log[0].rs, iss_log[0].rt,
                 iss_log[0].ill);
      end
      n_cmp++;
      if ({iss_log[1].pc, iss_log[1].op, iss_log[1].rd, iss_log[1].ill} !== {8'h61, 8'h1D, 1'b0})
      begin
        n_bad++;
        $display("FAIL illegal_next: pc=%h op=%h rd=%h ill=%b required 61/1/D/0",
                 iss_log[1].pc, iss_log[1].op, iss_log[1].rd, iss_log[1].ill);
      end
    end
    n_cmp++;
    if (ill_cycles !== 1) begin
      n_bad++;
      $display("FAIL illegal_pulse: high for %0d cycles required 1", ill_cycles);
    end
    n_cmp++;
    if (req_log.size() !== 3) begin
      n_bad++;
      $display("FAIL illegal_withdraw: requests=%0d required 3 (60..62)", req_log.size());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [3] = '{8'hFE, 8'hFF, 8'h00};
    do_reset();
    clear_mem();
    mem[8'hFE] = 16'h1001;
    mem[8'hFF] = 16'h2002;
    mem[8'h00] = 16'hB000;
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    do_start(8'hFE);
    run_to_halt("wrap");
    n_cmp++;
    if (req_log.size() !== 3 || iss_log.size() !== 3) begin
      n_bad++;
      $display("FAIL wrap_count: requests=%0d issued=%0d required 3/3", req_log.size(),
               iss_log.size());
    end
    for (int i = 0; i < 3 && i < req_log.size() && i < iss_log.size(); i++) begin
      n_cmp++;
      if (req_log[i] !== exp_a[i] || iss_log[i].pc !== exp_a[i]) begin
        n_bad++;
        $display("FAIL wrap_addr%0d: req=%h dec_pc=%h required %h", i, req_log[i],
                 iss_log[i].pc, exp_a[i]);
      end
    end
  endtask

  task automatic test_backpressure_halt();
    do_reset();
    clear_mem();
    mem[8'h20] = 16'hB000;
    mem[8'h21] = 16'h1111;
    mem[8'h22] = 16'h2222;
    lat = 3;
    bus.imem_req_ready = 1'b0;
    bus.dec_ready      = 1'b1;
    do_start(8'h20);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'h20) begin
        n_bad++;
        $display("FAIL bp_hold%0d: v=%b addr=%h required 1/20", k, bus.imem_req_valid,
                 bus.imem_req_addr);
      end
      tick();
    end
    bus.imem_req_ready = 1'b1;
    run_to_halt("bp");
    n_cmp++;
    if (req_log.size() !== 2 || (req_log.size() == 2 && req_log[1] !== 8'h21)) begin
      n_bad++;
      $display("FAIL bp_reqs: requests=%0d required 2 (20,21)", req_log.size());
    end
    n_cmp++;
    if (iss_log.size() !== 1 || (iss_log.size() == 1 && iss_log[0].op !== 4'hB)) begin
      n_bad++;
      $display("FAIL bp_single_halt: issued=%0d required exactly one HALT", iss_log.size());
    end
    n_cmp++;
    if (halted_cyc !== last_resp_cyc + 1) begin
      n_bad++;
      $display("FAIL bp_halt_after_stale: halted at %0d required %0d", halted_cyc,
               last_resp_cyc + 1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_mem();
    mem[8'h80] = 16'h1000;
    mem[8'h81] = 16'h2000;
    mem[8'h90] = 16'h3ABC;
    mem[8'h91] = 16'hB000;
    lat = 3;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    do_start(8'h80);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.imem_req_valid, bus.imem_req_addr, bus.dec_valid, bus.dec_opcode, bus.dec_pc,
         bus.illegal, bus.halted, bus.busy} !== 25'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: req_v=%b addr=%h dec_v=%b busy=%b required all 0",
               bus.imem_req_valid, bus.imem_req_addr, bus.dec_valid, bus.busy);
    end
    clear_logs();
    tick();
    reset_n = 1'b1;
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (iss_log.size() !== 0 || bus.dec_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_stale_ignored: issued=%0d dec_v=%b busy=%b required 0/0/0",
               iss_log.size(), bus.dec_valid, bus.busy);
    end
    lat = 1;
    do_start(8'h90);
    run_to_halt("restart");
    n_cmp++;
    if (iss_log.size() !== 2 ||
        (iss_log.size() == 2 && ({iss_log[0].pc, iss_log[0].op, iss_log[0].rd} !== 16'h903A ||
                                 iss_log[1].pc !== 8'h91))) begin
      n_bad++;
      $display("FAIL restart_issue: issued=%0d required 90(op3 rdA) then 91", iss_log.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    lat   = 1;
    stray = 1'b0;
    reset_n = 1'b0;
    bus.start           = 1'b0;
    bus.start_pc        = 8'h00;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 16'h0000;
    bus.dec_ready       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      pa[i] = 8'h00;
    end
    clear_mem();
    clear_logs();
    test_reset();
    test_straight();
    test_stall();
    test_illegal();
    test_wrap();
    test_backpressure_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
